// File: rtl/hazard_if.sv
// Pipeline-hazard bundle between the ID-stage sequencer and the pipeline datapath.
interface hazard_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             idex_memread;
   logic [4:0]       idex_rt;
   logic             branch_taken;
   logic             jump_id;
   logic             md_start;
   logic             md_done;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             md_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Datapath side: reports hazard sources, obeys enables/flushes.
   modport master (
      output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
             branch_taken, jump_id, md_start, md_done,
      input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
             md_timeout, stall_cnt, flush_cnt
   );

   // Sequencer side.
   modport slave (
      input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
             branch_taken, jump_id, md_start, md_done,
      output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
             md_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/jump squashes, mul/div freeze,
// saturating stall/flush statistics. Controls are combinational from state + inputs.
module hazard_ctrl #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned MD_MAX = 64
) (
   input logic     clk,
   input logic     rst_n,
   hazard_if.slave hz
);
   localparam int unsigned MD_W = (MD_MAX > 2) ? $clog2(MD_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   typedef enum logic {
      ST_RUN,
      ST_MD_WAIT
   } state_e;

   state_e           state_q, state_d;
   logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
   logic             md_timeout_q, md_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic freeze_c, load_use_c;
   logic pc_en_c, ifid_en_c, idex_en_c;
   logic ifid_flush_c, idex_flush_c, exmem_flush_c;

   // Load-use hazard against a load in EX; $zero is never a real dependency.
   assign load_use_c = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                       ((hz.idex_rt == hz.ifid_rs) ||
                        (hz.ifid_uses_rt && (hz.idex_rt == hz.ifid_rt)));

   // Freeze covers the issue cycle and every wait cycle except the one with md_done.
   assign freeze_c = ((state_q == ST_MD_WAIT) && !hz.md_done) ||
                     ((state_q == ST_RUN) && hz.md_start);

   // Prioritised hazard resolution; reset forces a clean squashed pipeline.
   always_comb begin
      pc_en_c       = 1'b1;
      ifid_en_c     = 1'b1;
      idex_en_c     = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_flush_c  = 1'b0;
      exmem_flush_c = 1'b0;
      if (freeze_c) begin
         pc_en_c       = 1'b0;
         ifid_en_c     = 1'b0;
         idex_en_c     = 1'b0;
         exmem_flush_c = 1'b1;
      end else if (hz.branch_taken) begin
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
      end else if (load_use_c) begin
         pc_en_c      = 1'b0;
         ifid_en_c    = 1'b0;
         idex_flush_c = 1'b1;
      end else if (hz.jump_id) begin
         ifid_flush_c = 1'b1;
      end
      if (!rst_n) begin
         pc_en_c       = 1'b0;
         ifid_en_c     = 1'b0;
         idex_en_c     = 1'b0;
         ifid_flush_c  = 1'b1;
         idex_flush_c  = 1'b1;
         exmem_flush_c = 1'b0;
      end
   end

   // Next state: mul/div wait tracking with timeout, saturating statistics.
   always_comb begin
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      md_timeout_d = md_timeout_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (hz.md_start) begin
               state_d  = ST_MD_WAIT;
               md_cnt_d = '0;
            end
         end
         ST_MD_WAIT: begin
            if (hz.md_done) begin
               state_d = ST_RUN;
            end else if (md_cnt_q == MD_W'(MD_MAX - 1)) begin
               md_timeout_d = 1'b1;
               state_d      = ST_RUN;
            end else begin
               md_cnt_d = md_cnt_q + MD_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (!pc_en_c && (stall_cnt_q != CNT_SAT)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ifid_flush_c && (flush_cnt_q != CNT_SAT)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State and statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         md_cnt_q     <= '0;
         md_timeout_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         md_cnt_q     <= md_cnt_d;
         md_timeout_q <= md_timeout_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign hz.pc_en       = pc_en_c;
   assign hz.ifid_en     = ifid_en_c;
   assign hz.idex_en     = idex_en_c;
   assign hz.ifid_flush  = ifid_flush_c;
   assign hz.idex_flush  = idex_flush_c;
   assign hz.exmem_flush = exmem_flush_c;
   assign hz.md_timeout  = md_timeout_q;
   assign hz.stall_cnt   = stall_cnt_q;
   assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instance A (CNT_W=4, MD_MAX=8) for hazards, timeout and
// saturation; instance B (defaults) for the 10-cycle mul/div freeze.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] ifid_rs, ifid_rt, idex_rt;
   logic ifid_uses_rt, idex_memread, branch_taken, jump_id;
   logic md_start_a, md_done_a, md_start_b, md_done_b;

   int checks = 0;
   int failures = 0;
   int exp_stall, exp_flush;

   localparam logic [5:0] O_DEF    = 6'b111000;
   localparam logic [5:0] O_FREEZE = 6'b000001;
   localparam logic [5:0] O_LU     = 6'b001010;
   localparam logic [5:0] O_BR     = 6'b111110;
   localparam logic [5:0] O_JMP    = 6'b111100;
   localparam logic [5:0] O_RST    = 6'b000110;

   always #5 clk = ~clk;

   hazard_if #(.CNT_W(4))  if_a ();
   hazard_if #(.CNT_W(16)) if_b ();

   assign if_a.ifid_rs = ifid_rs;           assign if_b.ifid_rs = ifid_rs;
   assign if_a.ifid_rt = ifid_rt;           assign if_b.ifid_rt = ifid_rt;
   assign if_a.ifid_uses_rt = ifid_uses_rt; assign if_b.ifid_uses_rt = ifid_uses_rt;
   assign if_a.idex_memread = idex_memread; assign if_b.idex_memread = idex_memread;
   assign if_a.idex_rt = idex_rt;           assign if_b.idex_rt = idex_rt;
   assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken;
   assign if_a.jump_id = jump_id;           assign if_b.jump_id = jump_id;
   assign if_a.md_start = md_start_a;       assign if_b.md_start = md_start_b;
   assign if_a.md_done = md_done_a;         assign if_b.md_done = md_done_b;

   hazard_ctrl #(.CNT_W(4), .MD_MAX(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .hz(if_a.slave));
   hazard_ctrl #(.CNT_W(16), .MD_MAX(64)) u_dut_b (.clk(clk), .rst_n(rst_n), .hz(if_b.slave));

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       memread;
      logic [4:0] ex_rt;
      logic       br;
      logic       jmp;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [5:0] outs_a();
      return {if_a.pc_en, if_a.ifid_en, if_a.idex_en,
              if_a.ifid_flush, if_a.idex_flush, if_a.exmem_flush};
   endfunction

   function automatic logic [5:0] outs_b();
      return {if_b.pc_en, if_b.ifid_en, if_b.idex_en,
              if_b.ifid_flush, if_b.idex_flush, if_b.exmem_flush};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
      ifid_uses_rt = 1'b0; idex_memread = 1'b0; branch_taken = 1'b0; jump_id = 1'b0;
      md_start_a = 1'b0; md_done_a = 1'b0; md_start_b = 1'b0; md_done_b = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      idle();
      @(negedge clk);
      chk("rst_outs_a", 32'(outs_a()), 32'(O_RST));
      chk("rst_stall_a", 32'(if_a.stall_cnt), 32'd0);
      chk("rst_flush_a", 32'(if_a.flush_cnt), 32'd0);
      chk("rst_tmo_a", 32'(if_a.md_timeout), 32'd0);
      chk("rst_outs_b", 32'(outs_b()), 32'(O_RST));
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Model of the saturating 4-bit statistics of instance A.
   task automatic model_count(input logic [5:0] o);
      if (!o[5] && exp_stall < 15) exp_stall++;
      if (o[2] && exp_flush < 15) exp_flush++;
   endtask

   task automatic apply_vec(input vec_t v);
      ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rt = v.uses_rt;
      idex_memread = v.memread; idex_rt = v.ex_rt; branch_taken = v.br; jump_id = v.jmp;
   endtask

   initial begin
      //          rs     rt     use   mrd   ex_rt  br    jmp   expected
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_DEF};
      vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, O_LU};
      vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_DEF};
      vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, O_DEF};
      vecs[4]  = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, O_DEF};
      vecs[5]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, O_LU};
      vecs[6]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, O_DEF};
      vecs[7]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, O_BR};
      vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_JMP};
      vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, O_BR};
      vecs[10] = '{5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, O_LU};

      rst_n = 1'b0;
      idle();
      apply_reset();

      // 10-cycle mul/div on B; a branch and a repeated md_start during the wait change nothing.
      next_cycle(); idle(); md_start_b = 1'b1;
      @(negedge clk); chk("md_freeze_b_0", 32'(outs_b()), 32'(O_FREEZE));
      for (int i = 1; i < 10; i++) begin
         next_cycle(); idle();
         if (i == 3) branch_taken = 1'b1;
         if (i == 5) md_start_b = 1'b1;
         @(negedge clk); chk($sformatf("md_freeze_b_%0d", i), 32'(outs_b()), 32'(O_FREEZE));
      end
      next_cycle(); idle(); md_done_b = 1'b1;
      @(negedge clk); chk("md_release_b", 32'(outs_b()), 32'(O_DEF));
      next_cycle(); idle();
      @(negedge clk);
      chk("md_run_b", 32'(outs_b()), 32'(O_DEF));
      chk("md_stall_b", 32'(if_b.stall_cnt), 32'd10);
      chk("md_flush_b", 32'(if_b.flush_cnt), 32'd0);

      // Single-cycle hazard table on A with counter model.
      apply_reset();
      exp_stall = 0; exp_flush = 0;
      foreach (vecs[i]) begin
         next_cycle(); idle(); apply_vec(vecs[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_outs", i), 32'(outs_a()), 32'(vecs[i].exp));
         chk($sformatf("vec%0d_stall", i), 32'(if_a.stall_cnt), 32'(exp_stall));
         chk($sformatf("vec%0d_flush", i), 32'(if_a.flush_cnt), 32'(exp_flush));
         model_count(vecs[i].exp);
      end
      next_cycle(); idle();
      @(negedge clk);
      chk("tbl_stall", 32'(if_a.stall_cnt), 32'(exp_stall));
      chk("tbl_flush", 32'(if_a.flush_cnt), 32'(exp_flush));

      // Mul/div timeout on A: issue cycle + 8 wait cycles frozen, then sticky timeout.
      next_cycle(); idle(); md_start_a = 1'b1;
      @(negedge clk);
      chk("tmo_freeze_0", 32'(outs_a()), 32'(O_FREEZE));
      model_count(O_FREEZE);
      for (int i = 1; i <= 8; i++) begin
         next_cycle(); idle();
         @(negedge clk);
         chk($sformatf("tmo_freeze_%0d", i), 32'(outs_a()), 32'(O_FREEZE));
         chk($sformatf("tmo_flag_%0d", i), 32'(if_a.md_timeout), 32'd0);
         model_count(O_FREEZE);
      end
      next_cycle(); idle();
      @(negedge clk);
      chk("tmo_run", 32'(outs_a()), 32'(O_DEF));
      chk("tmo_flag", 32'(if_a.md_timeout), 32'd1);
      chk("tmo_stall", 32'(if_a.stall_cnt), 32'(exp_stall));
      next_cycle(); idle(); md_done_a = 1'b1;
      @(negedge clk);
      chk("done_in_run", 32'(outs_a()), 32'(O_DEF));
      chk("tmo_sticky", 32'(if_a.md_timeout), 32'd1);

      // Saturation of both 4-bit counters.
      for (int i = 0; i < 8; i++) begin
         next_cycle(); idle(); apply_vec(vecs[1]);
         model_count(O_LU);
      end
      for (int i = 0; i < 16; i++) begin
         next_cycle(); idle(); branch_taken = 1'b1;
         model_count(O_BR);
      end
      next_cycle(); idle();
      @(negedge clk);
      chk("sat_stall", 32'(if_a.stall_cnt), 32'd15);
      chk("sat_flush", 32'(if_a.flush_cnt), 32'd15);
      chk("sat_model", 32'(if_a.stall_cnt), 32'(exp_stall));
      chk("tmo_still", 32'(if_a.md_timeout), 32'd1);

      // Asynchronous reset in the middle of an MD_WAIT.
      next_cycle(); idle(); md_start_a = 1'b1;
      next_cycle(); idle();
      next_cycle(); idle();
      @(negedge clk); chk("mid_wait_freeze", 32'(outs_a()), 32'(O_FREEZE));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 32'(outs_a()), 32'(O_RST));
      chk("async_rst_stall", 32'(if_a.stall_cnt), 32'd0);
      chk("async_rst_flush", 32'(if_a.flush_cnt), 32'd0);
      chk("async_rst_tmo", 32'(if_a.md_timeout), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_run", 32'(outs_a()), 32'(O_DEF));
      chk("post_rst_stall", 32'(if_a.stall_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
